// File: rtl/fc_func_pipe.sv
// FC-layer functional unit: walks obuf addresses across horizontal tiles, sums vertical-tile
// partials, then shifts, optionally ReLUs, saturates and streams results with valid/ready.
module fc_func_pipe #(
  parameter int unsigned INPUT_SIZE           = 257,
  parameter int unsigned OUTPUT_SIZE          = 512,
  parameter int unsigned XBAR_SIZE            = 256,
  parameter int unsigned DATATYPE_SIZE        = 8,
  parameter int unsigned OUTPUT_DATATYPE_SIZE = 8,
  parameter int unsigned SHIFT_WIDTH          = 4,
  localparam int unsigned V_CIM_TILES = (INPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int unsigned H_CIM_TILES = (OUTPUT_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int unsigned AW = (XBAR_SIZE > 1) ? $clog2(XBAR_SIZE) : 1,
  localparam int unsigned TW = (H_CIM_TILES > 1) ? $clog2(H_CIM_TILES) : 1
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        i_start,
  input  logic                                                        i_cim_busy,
  input  logic                                                        i_next_busy,
  input  logic                                                        i_relu_en,
  input  logic [SHIFT_WIDTH-1:0]                                      i_shift,
  input  logic [V_CIM_TILES-1:0][H_CIM_TILES-1:0][DATATYPE_SIZE-1:0] i_data,
  output logic [AW-1:0]                                               o_cim_addr,
  output logic [TW-1:0]                                               o_cim_tile,
  output logic [OUTPUT_DATATYPE_SIZE-1:0]                             o_data,
  output logic                                                        o_valid,
  input  logic                                                        i_ready,
  output logic                                                        o_busy,
  output logic                                                        o_start_next
);

  localparam int unsigned CW = $clog2(OUTPUT_SIZE + 1);
  localparam int unsigned SW = DATATYPE_SIZE + $clog2(V_CIM_TILES) + 1;
  localparam int unsigned OW = OUTPUT_DATATYPE_SIZE;
  localparam int unsigned EW = SW + OW;

  localparam logic signed [EW-1:0] SAT_MAX   = EW'((64'd1 << (OW - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SAT_MIN   = ~SAT_MAX;
  localparam logic [CW-1:0]        LAST_N    = CW'(OUTPUT_SIZE - 1);
  localparam logic [AW-1:0]        LAST_ADDR = AW'(XBAR_SIZE - 1);

  typedef logic [V_CIM_TILES-1:0][H_CIM_TILES-1:0][DATATYPE_SIZE-1:0] obuf_t;

  typedef enum logic [2:0] {
    s_reset, s_wait, s_read, s_drain, s_done, s_start
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [TW-1:0]            tile_q, tile_d;
  logic [CW-1:0]            n_q, n_d;
  logic [CW-1:0]            xfer_cnt_q, xfer_cnt_d;
  logic                     relu_q, relu_d;
  logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
  logic                     dv_q;
  logic [TW-1:0]            dtile_q;
  logic                     stall_q;
  obuf_t                    hold_q;
  logic                     s1_v_q;
  logic signed [SW-1:0]     s1_q;
  logic                     o_valid_q;
  logic [OW-1:0]            o_data_q;
  logic                     o_busy_q;
  logic                     o_start_next_q;

  logic                     stall_c, adv_c, xfer_c, issue_c;
  obuf_t                    src_c;
  logic signed [SW-1:0]     sum_c;
  logic signed [SW-1:0]     shifted_c;
  logic signed [EW-1:0]     ext_c;
  logic [OW-1:0]            act_c;

  // Whole pipeline freezes while a presented result is not taken.
  assign stall_c = o_valid_q & ~i_ready;
  assign adv_c   = ~stall_c;
  assign xfer_c  = o_valid_q & i_ready;

  // Next-state, address walk and transfer counting.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tile_d     = tile_q;
    n_d        = n_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    xfer_cnt_d = xfer_cnt_q + CW'(xfer_c);
    issue_c    = 1'b0;
    case (state_q)
      s_reset: begin
        xfer_cnt_d = '0;
        if (i_start) begin
          relu_d  = i_relu_en;
          shift_d = i_shift;
          if (i_cim_busy) begin
            state_d = s_wait;
          end else begin
            issue_c = 1'b1;
            state_d = s_read;
          end
        end
      end
      s_wait: begin
        if (!i_cim_busy) begin
          issue_c = 1'b1;
          state_d = s_read;
        end
      end
      s_read:  issue_c = adv_c;
      s_drain: if (xfer_c && xfer_cnt_q == LAST_N) state_d = s_done;
      s_done:  if (!i_next_busy) state_d = s_start;
      s_start: state_d = s_reset;
      default: state_d = s_reset;
    endcase
    // The address on o_cim_addr is read by the obuf at the end of an issuing cycle.
    if (issue_c) begin
      if (n_q == LAST_N) begin
        addr_d  = '0;
        tile_d  = '0;
        n_d     = '0;
        state_d = s_drain;
      end else begin
        n_d = n_q + CW'(1);
        if (addr_q == LAST_ADDR) begin
          addr_d = '0;
          tile_d = tile_q + TW'(1);
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
    end
  end

  // After a stall the obuf already shows the next address, so replay the captured word.
  always_comb begin
    src_c = stall_q ? hold_q : i_data;
    sum_c = '0;
    for (int v = 0; v < int'(V_CIM_TILES); v++) begin
      sum_c = sum_c + SW'($signed(src_c[v][dtile_q]));
    end
  end

  // Scale, activate, saturate.
  always_comb begin
    shifted_c = s1_q >>> shift_q;
    ext_c     = EW'(shifted_c);
    if (relu_q && ext_c[EW-1]) ext_c = '0;
    if (ext_c > SAT_MAX)      act_c = SAT_MAX[OW-1:0];
    else if (ext_c < SAT_MIN) act_c = SAT_MIN[OW-1:0];
    else                      act_c = ext_c[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= s_reset;
      addr_q         <= '0;
      tile_q         <= '0;
      n_q            <= '0;
      xfer_cnt_q     <= '0;
      relu_q         <= 1'b0;
      shift_q        <= '0;
      dv_q           <= 1'b0;
      dtile_q        <= '0;
      stall_q        <= 1'b0;
      hold_q         <= '0;
      s1_v_q         <= 1'b0;
      s1_q           <= '0;
      o_valid_q      <= 1'b0;
      o_data_q       <= '0;
      o_busy_q       <= 1'b0;
      o_start_next_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      tile_q         <= tile_d;
      n_q            <= n_d;
      xfer_cnt_q     <= xfer_cnt_d;
      relu_q         <= relu_d;
      shift_q        <= shift_d;
      o_busy_q       <= state_d inside {s_wait, s_read, s_drain, s_done};
      o_start_next_q <= (state_d == s_start);
      stall_q        <= stall_c;
      if (stall_c && !stall_q) hold_q <= i_data;
      if (adv_c) begin
        dv_q      <= issue_c;
        dtile_q   <= tile_q;
        s1_v_q    <= dv_q;
        s1_q      <= sum_c;
        o_valid_q <= s1_v_q;
        if (s1_v_q) o_data_q <= act_c;
      end
    end
  end

  assign o_cim_addr   = addr_q;
  assign o_cim_tile   = tile_q;
  assign o_data       = o_data_q;
  assign o_valid      = o_valid_q;
  assign o_busy       = o_busy_q;
  assign o_start_next = o_start_next_q;

endmodule
